mem_port_arbiter: RTL

Sequencer and arbiter that shares one single-port instruction/data memory between the core's instruction-fetch path and its load/store path. It grants one requester at a time and drives the memory port with registered request signals. It waits for the memory's ready response, then returns read data and a one-cycle acknowledge to the granted requester. A watchdog aborts transactions that the memory never completes.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// Round-robin on ties, registered memory port, watchdog abort.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ready
);

  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state, state_d;
  logic          own_dat, last_dat;
  logic          gnt_if, gnt_d, done, tmo;
  logic [CW-1:0] cnt, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    gnt_if  = 1'b0;
    gnt_d   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        // on a tie, the requester not served last wins
        unique case (1'b1)
          (if_req && (!d_req || last_dat)): gnt_if = 1'b1;
          (d_req && (!if_req || !last_dat)): gnt_d = 1'b1;
          default: ;
        endcase
        if (gnt_if || gnt_d) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (m_ready) begin
          done    = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt + 1'b1;
          if (TIMEOUT != 0 && cnt_d == CW'(TIMEOUT)) begin
            tmo     = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      own_dat  <= 1'b0;
      last_dat <= 1'b1;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_rdata <= '0;
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      d_rdata  <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      if (gnt_if) begin
        m_req    <= 1'b1;
        m_we     <= 1'b0;
        m_addr   <= if_addr;
        m_wdata  <= '0;
        m_be     <= '1;
        own_dat  <= 1'b0;
        last_dat <= 1'b0;
      end
      if (gnt_d) begin
        m_req    <= 1'b1;
        m_we     <= d_we;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        m_be     <= d_be;
        own_dat  <= 1'b1;
        last_dat <= 1'b1;
      end
      if (done || tmo) begin
        m_req <= 1'b0;
        if (own_dat) begin
          d_ack   <= 1'b1;
          d_err   <= tmo;
          d_rdata <= (tmo || m_we) ? '0 : m_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_err   <= tmo;
          if_rdata <= tmo ? '0 : m_rdata;
        end
      end
    end
  end

endmodule
